// File: rtl/common.sv
// Shared types for the 64-bit core: ALU operation encoding, the EX/MEM
// pipeline register layout and register-file constants.
package common;

  // ALU operation selector driven by decode.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alufunc_t;

  // Contents of the EX/MEM output register.
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] result;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
  } ex_mem_t;

  // x0 is hard-wired to zero and never written or forwarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/alu.sv
// Combinational 64-bit integer ALU. Arithmetic wraps modulo 2^64; shift
// amounts use the low six bits of operand b.
module alu
  import common::*;
(
  input  alufunc_t    func,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] r
);

  // Select the operation result.
  always_comb begin
    r = '0;
    unique case (func)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[5:0];
      ALU_SLT:  r = {63'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {63'd0, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[5:0];
      ALU_SRA:  r = $signed(a) >>> b[5:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: operand selection, ALU, RV64 word-op sign extension and
// the EX/MEM output register with valid/ready handshaking on both sides.
// Optional feature macro: EXECUTE_BYPASS_EN forwards the EX/MEM result back
// into rs1/rs2 when the incoming instruction reads the register it writes.
module execute_stage
  import common::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [4:0]       in_rs1_idx,
  input  logic [4:0]       in_rs2_idx,
  input  logic [63:0]      in_rs1_data,
  input  logic [63:0]      in_rs2_data,
  input  logic [63:0]      in_imm,
  input  alufunc_t         in_alufunc,
  input  logic             in_a_sel,
  input  logic             in_b_sel,
  input  logic             in_word,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pc,
  output logic [63:0]      out_result,
  output logic [63:0]      out_store_data,
  output logic [4:0]       out_rd,
  output logic             out_regwrite,
  output logic [CNT_W-1:0] issued_cnt
);

  logic             out_valid_q, out_valid_d;
  ex_mem_t          ex_mem_q, ex_mem_d;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;

  logic [63:0] rs1_val, rs2_val;
  logic [63:0] op_a, op_b;
  logic [63:0] alu_r;
  logic [63:0] result_ext;
  logic        accept;

  // Register source values, optionally forwarded from the EX/MEM register.
`ifdef EXECUTE_BYPASS_EN
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
    if (out_valid_q && ex_mem_q.regwrite && ex_mem_q.rd != REG_ZERO &&
        ex_mem_q.rd == in_rs1_idx)
      rs1_val = ex_mem_q.result;
    if (out_valid_q && ex_mem_q.regwrite && ex_mem_q.rd != REG_ZERO &&
        ex_mem_q.rd == in_rs2_idx)
      rs2_val = ex_mem_q.result;
  end
`else
  logic unused_idx;
  assign unused_idx = ^{in_rs1_idx, in_rs2_idx};

  // Without forwarding the register file values are used as-is.
  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
  end
`endif

  // Operand muxes and W-op sign extension of the ALU result.
  always_comb begin
    op_a       = in_a_sel ? in_pc : rs1_val;
    op_b       = in_b_sel ? in_imm : rs2_val;
    result_ext = in_word ? {{32{alu_r[31]}}, alu_r[31:0]} : alu_r;
  end

  alu u_alu (
    .func (in_alufunc),
    .a    (op_a),
    .b    (op_b),
    .r    (alu_r)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Next-state for the output register and counter; flush beats accept/hold.
  always_comb begin
    ex_mem_d     = ex_mem_q;
    issued_cnt_d = issued_cnt_q;
    if (flush)
      out_valid_d = 1'b0;
    else if (accept)
      out_valid_d = 1'b1;
    else if (out_ready)
      out_valid_d = 1'b0;
    else
      out_valid_d = out_valid_q;
    if (accept) begin
      ex_mem_d.pc         = in_pc;
      ex_mem_d.result     = result_ext;
      ex_mem_d.store_data = rs2_val;
      ex_mem_d.rd         = in_rd;
      ex_mem_d.regwrite   = in_regwrite && (in_rd != REG_ZERO);
      issued_cnt_d        = issued_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      ex_mem_q     <= '0;
      issued_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      ex_mem_q     <= ex_mem_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = ex_mem_q.pc;
  assign out_result     = ex_mem_q.result;
  assign out_store_data = ex_mem_q.store_data;
  assign out_rd         = ex_mem_q.rd;
  assign out_regwrite   = ex_mem_q.regwrite;
  assign issued_cnt     = issued_cnt_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table-driven single-cycle vectors
// through a scoreboard queue, then hand-written stall/flush/reset/bypass
// sequences.
module tb_execute_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [63:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
  alufunc_t    in_alufunc;
  logic        in_a_sel, in_b_sel, in_word, in_regwrite;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic [63:0] issued_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_cnt = 0;

  execute_stage #(.CNT_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alufunc(in_alufunc), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .in_word(in_word), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    alufunc_t    f;
    logic        a_sel, b_sel, word;
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        rw;
    logic [63:0] exp_res;
    logic        exp_rw;
  } vec_t;

  typedef struct {
    logic [63:0] pc, res, sd, cnt;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(input alufunc_t f, input logic a_sel, input logic b_sel,
                       input logic word, input logic [63:0] pc, input logic [63:0] rs1,
                       input logic [63:0] rs2, input logic [63:0] imm,
                       input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_alufunc = f; in_a_sel = a_sel; in_b_sel = b_sel;
    in_word = word; in_pc = pc; in_rs1_data = rs1; in_rs2_data = rs2;
    in_imm = imm; in_rd = rd; in_regwrite = rw;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_idx = '0; in_rs2_idx = '0; in_rd = '0; in_alufunc = ALU_ADD;
    in_a_sel = 1'b0; in_b_sel = 1'b0; in_word = 1'b0; in_regwrite = 1'b0;

    //            f         as    bs    w     pc        rs1                    rs2                    imm     rd  rw    result                 rw
    vecs[0]  = '{ALU_ADD,  1'b0, 1'b0, 1'b0, 64'h100, 64'd7,                 64'd5,                 64'd0,  5,  1'b1, 64'd12,                1'b1};
    vecs[1]  = '{ALU_SUB,  1'b0, 1'b0, 1'b1, 64'h104, 64'd0,                 64'd1,                 64'd0,  6,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2]  = '{ALU_ADD,  1'b0, 1'b1, 1'b1, 64'h108, 64'h7FFF_FFFF,         64'd9,                 64'd1,  7,  1'b1, 64'hFFFF_FFFF_8000_0000, 1'b1};
    vecs[3]  = '{ALU_ADD,  1'b1, 1'b1, 1'b0, 64'h1000, 64'd3,                64'd4,                 64'h10, 1,  1'b1, 64'h1010,              1'b1};
    vecs[4]  = '{ALU_XOR,  1'b0, 1'b0, 1'b0, 64'h110, 64'hF0F0,              64'h0FF0,              64'd0,  8,  1'b1, 64'hFF00,              1'b1};
    vecs[5]  = '{ALU_AND,  1'b0, 1'b0, 1'b0, 64'h114, 64'hFF00,              64'h0F0F,              64'd0,  9,  1'b1, 64'h0F00,              1'b1};
    vecs[6]  = '{ALU_OR,   1'b0, 1'b0, 1'b0, 64'h118, 64'hFF00,              64'h0F0F,              64'd0,  10, 1'b0, 64'hFF0F,              1'b0};
    vecs[7]  = '{ALU_SLT,  1'b0, 1'b0, 1'b0, 64'h11C, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               64'd0,  11, 1'b1, 64'd1,                 1'b1};
    vecs[8]  = '{ALU_SLTU, 1'b0, 1'b0, 1'b0, 64'h120, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               64'd0,  12, 1'b1, 64'd0,                 1'b1};
    vecs[9]  = '{ALU_SLL,  1'b0, 1'b0, 1'b0, 64'h124, 64'd1,                 64'd63,                64'd0,  13, 1'b1, 64'h8000_0000_0000_0000, 1'b1};
    vecs[10] = '{ALU_SRA,  1'b0, 1'b0, 1'b0, 64'h128, 64'h8000_0000_0000_0000, 64'd4,               64'd0,  14, 1'b1, 64'hF800_0000_0000_0000, 1'b1};
    vecs[11] = '{ALU_SRL,  1'b0, 1'b0, 1'b0, 64'h12C, 64'h8000_0000_0000_0000, 64'd4,               64'd0,  15, 1'b1, 64'h0800_0000_0000_0000, 1'b1};
    vecs[12] = '{ALU_ADD,  1'b0, 1'b0, 1'b0, 64'h130, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,               64'd0,  0,  1'b1, 64'd0,                 1'b0};

    // Reset held two cycles.
    step(); step();
    reset = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_result", out_result, 64'd0);
    chk("reset_pc", out_pc, 64'd0);
    chk("reset_store_data", out_store_data, 64'd0);
    chk("reset_rd_rw", {58'd0, out_rd, out_regwrite}, 64'd0);
    chk("reset_cnt", issued_cnt, 64'd0);
    $display("[TB] reset: out_valid=%0b in_ready=%0b cnt=%0d", out_valid, in_ready, issued_cnt);

    // Back-to-back table vectors with MEM always ready.
    for (int i = 0; i < 13; i++) begin
      exp_t e;
      drive(vecs[i].f, vecs[i].a_sel, vecs[i].b_sel, vecs[i].word, vecs[i].pc,
            vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].rd, vecs[i].rw);
      exp_cnt = exp_cnt + 1;
      e.pc = vecs[i].pc; e.res = vecs[i].exp_res; e.sd = vecs[i].rs2;
      e.rd = vecs[i].rd; e.rw = vecs[i].exp_rw; e.cnt = exp_cnt;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      chk("vec_valid", {63'd0, out_valid}, 64'd1);
      chk("vec_result", out_result, e.res);
      chk("vec_pc", out_pc, e.pc);
      chk("vec_store_data", out_store_data, e.sd);
      chk("vec_rd", {59'd0, out_rd}, {59'd0, e.rd});
      chk("vec_regwrite", {63'd0, out_regwrite}, {63'd0, e.rw});
      chk("vec_cnt", issued_cnt, e.cnt);
      $display("[TB] vec %0d: func=%0d result=0x%h rd=%0d rw=%0b cnt=%0d",
               i, vecs[i].f, out_result, out_rd, out_regwrite, issued_cnt);
    end

    // Stall: hold A for three cycles while B waits, then release.
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h200, 64'd1, 64'd2, 64'd0, 5'd6, 1'b1);
    exp_cnt = exp_cnt + 1;
    step();
    chk("stall_a_result", out_result, 64'd3);
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h204, 64'd10, 64'd20, 64'd0, 5'd7, 1'b1);
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      step();
      chk("stall_valid", {63'd0, out_valid}, 64'd1);
      chk("stall_result", out_result, 64'd3);
      chk("stall_rd", {59'd0, out_rd}, 64'd6);
      chk("stall_pc", out_pc, 64'h200);
      chk("stall_cnt", issued_cnt, exp_cnt);
      $display("[TB] stall cycle %0d: result=0x%h in_ready=%0b cnt=%0d", c, out_result, in_ready, issued_cnt);
    end
    out_ready = 1'b1;
    exp_cnt = exp_cnt + 1;
    step();
    chk("release_valid", {63'd0, out_valid}, 64'd1);
    chk("release_result", out_result, 64'd30);
    chk("release_rd", {59'd0, out_rd}, 64'd7);
    chk("release_cnt", issued_cnt, exp_cnt);
    $display("[TB] release: result=0x%h rd=%0d cnt=%0d", out_result, out_rd, issued_cnt);
    in_valid = 1'b0;
    step();
    chk("drain_valid", {63'd0, out_valid}, 64'd0);
    chk("drain_cnt", issued_cnt, exp_cnt);
    $display("[TB] drain: out_valid=%0b cnt=%0d", out_valid, issued_cnt);

    // Flush while holding a stalled instruction with a new one offered.
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h300, 64'd2, 64'd3, 64'd0, 5'd8, 1'b1);
    exp_cnt = exp_cnt + 1;
    step();
    out_ready = 1'b0;
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h304, 64'd4, 64'd4, 64'd0, 5'd9, 1'b1);
    step();
    chk("flush_held_result", out_result, 64'd5);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_cnt", issued_cnt, exp_cnt);
    $display("[TB] flush: out_valid=%0b cnt=%0d", out_valid, issued_cnt);

    // Reset in the middle of a stall.
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h400, 64'd6, 64'd6, 64'd0, 5'd10, 1'b1);
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b1;
    exp_cnt = 0;
    chk("rst_stall_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_stall_cnt", issued_cnt, exp_cnt);
    chk("rst_stall_result", out_result, 64'd0);
    $display("[TB] reset mid-stall: out_valid=%0b cnt=%0d", out_valid, issued_cnt);

    // Back-to-back dependency on x3 with stale register-file data.
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h500, 64'd10, 64'd0, 64'd0, 5'd3, 1'b1);
    in_rs1_idx = 5'd0; in_rs2_idx = 5'd0;
    step();
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h504, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
    in_rs1_idx = 5'd3; in_rs2_idx = 5'd3;
    step();
`ifdef EXECUTE_BYPASS_EN
    chk("bypass_result", out_result, 64'd20);
    chk("bypass_store_data", out_store_data, 64'd10);
`else
    chk("nobypass_result", out_result, 64'd0);
    chk("nobypass_store_data", out_store_data, 64'd0);
`endif
    $display("[TB] dep x3: result=0x%h store=0x%h", out_result, out_store_data);

    // Same dependency through x0: never forwarded, never written.
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h600, 64'd10, 64'd0, 64'd0, 5'd0, 1'b1);
    in_rs1_idx = 5'd0; in_rs2_idx = 5'd0;
    step();
    chk("x0_regwrite", {63'd0, out_regwrite}, 64'd0);
    chk("x0_result", out_result, 64'd10);
    drive(ALU_ADD, 1'b0, 1'b0, 1'b0, 64'h604, 64'd0, 64'd0, 64'd0, 5'd4, 1'b1);
    step();
    in_valid = 1'b0;
    chk("x0_dep_result", out_result, 64'd0);
    chk("x0_dep_cnt", issued_cnt, 64'd4);
    $display("[TB] dep x0: result=0x%h cnt=%0d", out_result, issued_cnt);

    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
